// File: rtl/effects_engine.sv
// Streaming per-pixel colour effects: reads a frame from source memory, applies the selected effect, writes it out.
// Define EFFECTS_ENGINE_THRESH_EN to add the mode-5 grayscale threshold; otherwise mode 5 passes pixels through.
module effects_engine #(
  parameter int unsigned CH_W    = 8,
  parameter int unsigned NUM_PIX = 900,
  parameter int unsigned ADDR_W  = $clog2(NUM_PIX)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          mode,
  input  logic [CH_W-1:0]     level,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [3*CH_W-1:0]   rd_data,
  output logic                wr_en,
  input  logic                wr_ready,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [3*CH_W-1:0]   wr_data,
  output logic                busy,
  output logic                done
);

  localparam int unsigned    PIX_W = 3 * CH_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PIX - 1);
  localparam logic [CH_W-1:0]   MAXV = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              state, state_nxt;
  logic                stall;
  logic                wr_fire;
  logic                start_acc;
  logic [2:0]          mode_q;
  logic [CH_W-1:0]     level_q;
  logic                s1_valid;
  logic [ADDR_W-1:0]   s1_addr;
  logic [PIX_W-1:0]    pix_out;
  logic [CH_W+1:0]     gray_sum;
  logic [CH_W-1:0]     gray;
  logic [CH_W-1:0]     ch;
  logic [CH_W:0]       sum;
  logic [CH_W-1:0]     res;

  assign wr_fire   = wr_en & wr_ready;
  assign start_acc = (state == S_IDLE) & start;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (rd_en && rd_addr == LAST) state_nxt = S_DRAIN;
      S_DRAIN: if (wr_fire && wr_addr == LAST) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read strobe drops in the stalled cycle itself so the memory keeps the unconsumed pixel
  always_comb begin
    stall = wr_en & ~wr_ready;
    rd_en = (state == S_RUN) & ~stall;
    busy  = (state != S_IDLE);
  end

  // Effect datapath on the pixel currently presented by the memory
  always_comb begin
    gray_sum = (CH_W+2)'(rd_data[PIX_W-1 -: CH_W])
             + ((CH_W+2)'(rd_data[2*CH_W-1 -: CH_W]) << 1)
             + (CH_W+2)'(rd_data[CH_W-1:0]);
    gray     = CH_W'(gray_sum >> 2);
    pix_out  = rd_data;
    ch       = '0;
    sum      = '0;
    res      = '0;
    for (int i = 0; i < 3; i++) begin
      ch  = rd_data[i*CH_W +: CH_W];
      sum = (CH_W+1)'(ch) + (CH_W+1)'(level_q);
      case (mode_q)
        3'd1:    res = sum[CH_W] ? MAXV : sum[CH_W-1:0];
        3'd2:    res = (ch > level_q) ? (ch - level_q) : '0;
        3'd3:    res = MAXV - ch;
        3'd4:    res = gray;
`ifdef EFFECTS_ENGINE_THRESH_EN
        3'd5:    res = (gray >= level_q) ? MAXV : '0;
`endif
        default: res = ch;
      endcase
      pix_out[i*CH_W +: CH_W] = res;
    end
  end

  // Address generation, pipeline registers and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= '0;
      level_q  <= '0;
      rd_addr  <= '0;
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
    end else begin
      if (start_acc) begin
        mode_q  <= mode;
        level_q <= level;
        rd_addr <= '0;
      end else if (rd_en && rd_addr != LAST) begin
        rd_addr <= rd_addr + ADDR_W'(1);
      end
      if (!stall) begin
        s1_valid <= rd_en;
        s1_addr  <= rd_addr;
        wr_en    <= s1_valid;
        if (s1_valid) begin
          wr_addr <= s1_addr;
          wr_data <= pix_out;
        end
      end
      done <= (state == S_DRAIN) && wr_fire && (wr_addr == LAST);
    end
  end

endmodule

// File: tb/tb_effects_engine.sv
// Directed bench for effects_engine: memory model, write monitor, and one linear stimulus sequence.
module tb_effects_engine;

  localparam int unsigned CH_W    = 8;
  localparam int unsigned NUM_PIX = 900;
  localparam int unsigned ADDR_W  = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [2:0]        mode;
  logic [CH_W-1:0]   level;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [23:0]       rd_data;
  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              busy;
  logic              done;

  logic [23:0] mem  [0:NUM_PIX-1];
  logic [23:0] wlog [0:NUM_PIX-1];
  int n_tests = 0;
  int n_fail  = 0;
  int nwr, order_err, exp_next;
  int d;

  effects_engine #(.CH_W(CH_W), .NUM_PIX(NUM_PIX)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .level(level),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Source memory: one-cycle read latency, holds data while rd_en is low
  always @(posedge clk)
    if (rd_en && int'(rd_addr) < NUM_PIX) rd_data <= mem[rd_addr];

  // Write monitor: logs accepted writes and checks address order
  always @(negedge clk)
    if (wr_en && wr_ready) begin
      if (int'(wr_addr) != exp_next) order_err++;
      if (int'(wr_addr) < NUM_PIX) wlog[wr_addr] = wr_data;
      exp_next++;
      nwr++;
    end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame from IDLE; returns edges from accept to done (-1 on timeout)
  task automatic run_frame(input logic [2:0] m, input logic [7:0] lv, input int stall_at,
                           output int done_at);
    logic [ADDR_W-1:0] ha;
    logic [23:0]       hd;
    logic              held;
    logic              stalled;
    nwr = 0; order_err = 0; exp_next = 0;
    for (int i = 0; i < NUM_PIX; i++) wlog[i] = '0;
    check("idle_before_start", {31'd0, busy}, 32'd0);
    mode = m; level = lv; start = 1'b1;
    tick();
    start = 1'b0; mode = ~m; level = ~lv;
    check("accept", {busy, done, rd_en, rd_addr}, {1'b1, 1'b0, 1'b1, 10'd0});
    done_at = -1; held = 1'b1; stalled = 1'b0;
    for (int n = 1; n <= 3000; n++) begin
      tick();
      start = (n == 100);
      if (done) begin
        done_at = n;
        start = 1'b0;
        check("done_in_idle", {done, busy}, 2'b10);
        break;
      end
      if (stall_at >= 0 && !stalled && wr_en && int'(wr_addr) == stall_at) begin
        stalled = 1'b1; wr_ready = 1'b0; ha = wr_addr; hd = wr_data;
        repeat (5) begin
          tick();
          n++;
          held &= (wr_en && !rd_en && wr_addr == ha && wr_data == hd);
        end
        wr_ready = 1'b1;
      end
    end
    start = 1'b0;
    if (stall_at >= 0) check("stall_hold", {31'd0, held & stalled}, 32'd1);
    check("write_count", nwr, NUM_PIX);
    check("write_order", order_err, 0);
  endtask

  initial begin
    logic [23:0] exp5;
    rst = 1'b1; start = 1'b0; mode = '0; level = '0; wr_ready = 1'b1;
    nwr = 0; order_err = 0; exp_next = 0;
    for (int i = 0; i < NUM_PIX; i++) mem[i] = {8'(i), 8'(i >> 2), 8'(i * 7)};
    repeat (3) tick();
    check("rst_ctl", {4'd0, rd_en, wr_en, busy, done, rd_addr, wr_addr}, 32'd0);
    check("rst_data", {8'd0, wr_data}, 32'd0);
    rst = 1'b0;
    tick();

    // Saturating add; mode/level are scrambled after accept and must be ignored
    mem[5] = {8'd200, 8'd100, 8'd250};
    run_frame(3'd1, 8'd70, -1, d);
    check("m1_pix", {8'd0, wlog[5]}, 32'h00FFAAFF);
    check("m1_done_cycle", d, 902);

    // Frames below start in the done cycle of the previous one
    mem[5] = {8'd50, 8'd70, 8'd71};
    run_frame(3'd2, 8'd70, -1, d);
    check("m2_pix", {8'd0, wlog[5]}, 32'h00000001);

    mem[5] = {8'd0, 8'd255, 8'd15};
    run_frame(3'd3, 8'd0, -1, d);
    check("m3_pix", {8'd0, wlog[5]}, 32'h00FF00F0);

    mem[5] = {8'd10, 8'd20, 8'd30};
    run_frame(3'd4, 8'd0, -1, d);
    check("m4_pix", {8'd0, wlog[5]}, 32'h00141414);

    run_frame(3'd5, 8'd21, -1, d);
`ifdef EFFECTS_ENGINE_THRESH_EN
    exp5 = 24'h000000;
`else
    exp5 = 24'h0A141E;
`endif
    check("m5_pix", {8'd0, wlog[5]}, {8'd0, exp5});

    mem[5] = {8'd200, 8'd100, 8'd250};
    run_frame(3'd7, 8'd70, 10, d);
    check("m7_pass", {8'd0, wlog[5]}, 32'h00C864FA);
    check("stall_pix10", {8'd0, wlog[10]}, {8'd0, 8'd10, 8'd2, 8'd70});
    check("stall_done_cycle", d, 907);

    // Mid-frame reset, asserted together with start
    mode = 3'd1; level = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2000 && int'(rd_addr) != 400; k++) tick();
    check("rst_reach_400", {22'd0, rd_addr}, 32'd400);
    rst = 1'b1; start = 1'b1;
    tick();
    check("midrst_ctl", {4'd0, rd_en, wr_en, busy, done, rd_addr, wr_addr}, 32'd0);
    check("midrst_data", {8'd0, wr_data}, 32'd0);
    rst = 1'b0; start = 1'b0;
    tick();

    run_frame(3'd0, 8'd0, -1, d);
    check("fresh_pix0", {8'd0, wlog[0]}, 32'd0);
    check("fresh_pix899", {8'd0, wlog[899]}, {8'd0, 8'(899), 8'(224), 8'(6293)});
    check("fresh_done_cycle", d, 902);
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/effects_engine.md
EFFECTS_ENGINE -- requirements
Module: effects_engine

Interface
REQ-001 SHALL have parameter CH_W, default 8, bits per colour channel.
REQ-002 SHALL have parameter NUM_PIX, default 900, pixels per frame.
REQ-003 SHALL have parameter ADDR_W, default $clog2(NUM_PIX), address width.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1  frame start request, honoured only in IDLE.
REQ-007 SHALL have port mode  input  3  effect select, sampled on accepted start.
REQ-008 SHALL have port level  input  CH_W  brightness offset / threshold, sampled on accepted start.
REQ-009 SHALL have port rd_en  output  1  source-memory read strobe.
REQ-010 SHALL have port rd_addr  output  ADDR_W  source-memory read address.
REQ-011 SHALL have port rd_data  input  3*CH_W  pixel {R,G,B}, valid one cycle after rd_en; memory holds it while rd_en low.
REQ-012 SHALL have port wr_en  output  1  destination write valid.
REQ-013 SHALL have port wr_ready  input  1  destination accepts write when high with wr_en.
REQ-014 SHALL have port wr_addr  output  ADDR_W  destination write address.
REQ-015 SHALL have port wr_data  output  3*CH_W  processed pixel {R,G,B}.
REQ-016 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-017 SHALL have port done  output  1  one-cycle pulse after last write accepted.

Function
REQ-018 SHALL implement FSM IDLE -> RUN on start; RUN -> DRAIN after read of address NUM_PIX-1; DRAIN -> IDLE after write of address NUM_PIX-1 accepted.
REQ-019 SHALL issue reads at addresses 0..NUM_PIX-1 in order, one per cycle when not stalled.
REQ-020 SHALL be a 2-stage pipeline: read-data stage, output register; pixel read at cycle t appears on wr_data at t+2 absent stall.
REQ-021 SHALL stall (hold rd_en low, hold rd_addr and all pipeline registers) while wr_en high and wr_ready low.
REQ-022 SHALL keep wr_addr equal to the read address of the pixel in wr_data.
REQ-023 SHALL compute per channel c, max M=2^CH_W-1: mode 0 pass; 1 min(c+level,M); 2 max(c-level,0); 3 M-c.
REQ-024 SHALL compute mode 4 grayscale g=(R+2G+B)>>2 in CH_W+2-bit arithmetic, replicated to all channels.
REQ-025 SHALL treat modes 6 and 7 as pass (mode 0).
REQ-026 SHALL ignore start, mode and level changes while busy.
REQ-027 SHALL assert done for exactly one cycle in the cycle after the last write handshake and be back in IDLE that cycle.
REQ-028 SHALL accept start in the cycle done is high, beginning a new frame next cycle.

Reset
REQ-029 SHALL on rst return to IDLE, clearing rd_en, wr_en, busy, done, rd_addr, wr_addr, wr_data to 0, including mid-frame; in-flight pixels are discarded.
REQ-030 SHALL take rst priority over start in the same cycle.

Configuration
REQ-031 SHALL, with macro EFFECTS_ENGINE_THRESH_EN defined, implement mode 5 threshold: all channels M if g>=level else 0.
REQ-032 SHALL, without EFFECTS_ENGINE_THRESH_EN, treat mode 5 as pass and include no threshold comparator.

Verification
REQ-033 SHALL cover mode 1, level 70, pixel {200,100,250} -> wr_data {255,170,255}.
REQ-034 SHALL cover mode 2, level 70, pixel {50,70,71} -> {0,0,1}; mode 3, {0,255,15} -> {255,0,240}.
REQ-035 SHALL cover mode 4, pixel {10,20,30} -> {20,20,20}; mode 5, level 21, with macro -> {0,0,0}, without -> {10,20,30}.
REQ-036 SHALL cover full 900-pixel frame, wr_ready always 1 -> 900 writes, addresses 0..899 in order, done at cycle 902 after start accepted.
REQ-037 SHALL cover wr_ready low 5 cycles at address 10 -> wr_data/wr_addr held, no skipped or duplicated address, done delayed 5 cycles.
REQ-038 SHALL cover rst at address 400 mid-frame -> all outputs 0 next cycle, IDLE, fresh start restarts at address 0.
